// File: rtl/search_job_sched.sv
// Round-robin job scheduler for the shared mk_SEARCH engine: accepts jobs from two
// requesters, sequences the engine through clear/run, returns tagged counts and keeps totals.
module search_job_sched #(
    parameter int unsigned ENG_LAT = 4,
    parameter int unsigned TOTW    = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req0_valid,
    input  logic [3:0]      req0_str,
    input  logic [7:0]      req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [3:0]      req1_str,
    input  logic [7:0]      req1_data,
    output logic            req1_ready,
    output logic            resp_valid,
    output logic            resp_id,
    output logic [7:0]      resp_num,
    input  logic            resp_ready,
    output logic [3:0]      eng_str,
    output logic [7:0]      eng_data,
    output logic [1:0]      eng_ctrl,
    input  logic [7:0]      eng_num,
    output logic [TOTW-1:0] tot0,
    output logic [TOTW-1:0] tot1,
    input  logic            clr_tot,
    output logic            busy
);

    localparam int unsigned     SUMW     = ((TOTW > 8) ? TOTW : 8) + 1;
    localparam logic [TOTW-1:0] TOT_MAX  = '1;
    localparam logic [3:0]      RUN_LOAD = 4'(ENG_LAT - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

    state_t          state, state_nx;
    logic            rr_ptr;
    logic            grant;
    logic            job_id;
    logic            accept;
    logic            capture;
    logic [3:0]      run_cnt;
    logic [TOTW-1:0] tot_sel;
    logic [TOTW-1:0] tot_upd;
    logic [SUMW-1:0] tot_sum;

    // rr_ptr holds the last grant; on a tie the other requester wins
    always_comb begin
        if (req0_valid && req1_valid) grant = ~rr_ptr;
        else                          grant = req1_valid;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            IDLE:  if (accept) state_nx = CLEAR;
            CLEAR: state_nx = RUN;
            RUN: begin
                if (run_cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:  if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Saturating add of the captured count into the owner's total
    always_comb begin
        tot_sel = job_id ? tot1 : tot0;
        tot_sum = SUMW'(tot_sel) + SUMW'(eng_num);
        tot_upd = (tot_sum > SUMW'(TOT_MAX)) ? TOT_MAX : TOTW'(tot_sum);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr     <= 1'b1;
            job_id     <= 1'b0;
            run_cnt    <= 4'd0;
            eng_str    <= 4'd0;
            eng_data   <= 8'd0;
            eng_ctrl   <= 2'b00;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_num   <= 8'd0;
            busy       <= 1'b0;
            tot0       <= '0;
            tot1       <= '0;
        end else begin
            busy       <= (state_nx != IDLE);
            eng_ctrl   <= (state_nx == RUN) ? 2'b01 : 2'b00;
            resp_valid <= (state_nx == RESP);
            if (accept) begin
                rr_ptr   <= grant;
                job_id   <= grant;
                eng_str  <= grant ? req1_str  : req0_str;
                eng_data <= grant ? req1_data : req0_data;
            end
            if (state == CLEAR)    run_cnt <= RUN_LOAD;
            else if (state == RUN) run_cnt <= run_cnt - 4'd1;
            if (capture) begin
                resp_id  <= job_id;
                resp_num <= eng_num;
            end
            // A clear coinciding with a capture discards that capture's increment
            if (clr_tot) begin
                tot0 <= '0;
                tot1 <= '0;
            end else if (capture) begin
                if (job_id) tot1 <= tot_upd;
                else        tot0 <= tot_upd;
            end
        end
    end

endmodule

// File: tb/tb_search_job_sched.sv
// Self-checking bench for search_job_sched: directed vector table, corner-case sequences
// and randomized traffic against a transaction-level reference model.
module tb_search_job_sched;

    localparam int unsigned ENG_LAT = 4;
    localparam int unsigned TOTW    = 4;
    localparam int          TMAX    = (1 << TOTW) - 1;

    logic            CLK = 1'b0;
    logic            RST;
    logic            req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]      req0_str, req1_str, eng_str;
    logic [7:0]      req0_data, req1_data, eng_data, eng_num, resp_num;
    logic            resp_valid, resp_id, resp_ready, clr_tot, busy;
    logic [1:0]      eng_ctrl;
    logic [TOTW-1:0] tot0, tot1;
    logic            force_en;
    logic [7:0]      force_val;

    search_job_sched #(.ENG_LAT(ENG_LAT), .TOTW(TOTW)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_str(req0_str), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_str(req1_str), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_num(resp_num), .resp_ready(resp_ready),
        .eng_str(eng_str), .eng_data(eng_data), .eng_ctrl(eng_ctrl), .eng_num(eng_num),
        .tot0(tot0), .tot1(tot1), .clr_tot(clr_tot), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Engine stand-in: number of 4-bit windows of data equal to the pattern
    function automatic int count_matches(input logic [3:0] s, input logic [7:0] d);
        int n = 0;
        for (int p = 0; p <= 4; p++) if (d[p +: 4] == s) n++;
        return n;
    endfunction

    assign eng_num = force_en ? force_val : 8'(count_matches(eng_str, eng_data));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: job-level view of the scheduler
    bit         m_job, m_id, m_rr;
    int         m_acc_edge, m_num;
    int         m_tot[2];
    logic [3:0] m_str;
    logic [7:0] m_data;
    bit         ev_acc, ev_rsp, ev_id;
    bit         clr_on_cap = 1'b0;

    task automatic model_reset();
        m_job = 1'b0; m_rr = 1'b1; m_id = 1'b0; m_num = 0;
        m_tot[0] = 0; m_tot[1] = 0; m_str = 4'd0; m_data = 8'd0;
    endtask

    // Inputs for this cycle are set by the caller just after a falling edge
    task automatic step();
        bit e0, e1, cap, rsp, cl, rv, run;
        logic [3:0] ns;
        logic [7:0] nd;
        #1;
        e0 = !m_job && req0_valid && (!req1_valid || m_rr);
        e1 = !m_job && req1_valid && (!req0_valid || !m_rr);
        chk("req0_ready", int'(req0_ready), int'(e0));
        chk("req1_ready", int'(req1_ready), int'(e1));
        cap = m_job && (cyc + 1 == m_acc_edge + 1 + ENG_LAT);
        rsp = m_job && (cyc >= m_acc_edge + 1 + ENG_LAT) && resp_ready;
        if (clr_on_cap && cap) clr_tot = 1'b1;
        cl = clr_tot;
        ns = e1 ? req1_str : req0_str;
        nd = e1 ? req1_data : req0_data;
        @(posedge CLK);
        cyc++;
        if (cap) m_num = force_en ? int'(force_val) : count_matches(m_str, m_data);
        if (cl) begin
            m_tot[0] = 0; m_tot[1] = 0;
        end else if (cap) begin
            m_tot[m_id] = (m_tot[m_id] + m_num > TMAX) ? TMAX : m_tot[m_id] + m_num;
        end
        if (rsp) m_job = 1'b0;
        ev_acc = e0 || e1; ev_rsp = rsp; ev_id = e1;
        if (ev_acc) begin
            m_job = 1'b1; m_id = e1; m_rr = e1; m_acc_edge = cyc; m_str = ns; m_data = nd;
        end
        @(negedge CLK);
        if (clr_on_cap) clr_tot = 1'b0;
        rv  = m_job && (cyc >= m_acc_edge + 1 + ENG_LAT);
        run = m_job && (cyc >= m_acc_edge + 1) && (cyc <= m_acc_edge + ENG_LAT);
        chk("busy", int'(busy), int'(m_job));
        chk("resp_valid", int'(resp_valid), int'(rv));
        if (rv) begin
            chk("resp_id", int'(resp_id), int'(m_id));
            chk("resp_num", int'(resp_num), m_num);
        end
        chk("eng_ctrl", int'(eng_ctrl), run ? 1 : 0);
        chk("eng_str", int'(eng_str), int'(m_str));
        chk("eng_data", int'(eng_data), int'(m_data));
        chk("tot0", int'(tot0), m_tot[0]);
        chk("tot1", int'(tot1), m_tot[1]);
    endtask

    typedef struct {
        logic v0; logic [3:0] s0; logic [7:0] d0;
        logic v1; logic [3:0] s1; logic [7:0] d1;
        int e_id; int e_num; int e_t0; int e_t1;
    } vec_t;

    task automatic run_job(input vec_t v, output int gid, output int gnum);
        int nrun = 0;
        bit done = 1'b0;
        gid = -1; gnum = -1;
        req0_valid = v.v0; req0_str = v.s0; req0_data = v.d0;
        req1_valid = v.v1; req1_str = v.s1; req1_data = v.d1;
        resp_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (ev_acc) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            if (eng_ctrl == 2'b01) nrun++;
            if (resp_valid) begin
                gid = int'(resp_id); gnum = int'(resp_num);
            end
            if (ev_rsp) done = 1'b1;
        end
        chk("job_completes", int'(done), 1);
        chk("run_cycles", nrun, ENG_LAT);
    endtask

    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 30 && m_job; i++) step();
        step();
        chk("drain_idle", int'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, int'(resp_valid), 0);
        chk({tag, "_resp_id"}, int'(resp_id), 0);
        chk({tag, "_resp_num"}, int'(resp_num), 0);
        chk({tag, "_eng_ctrl"}, int'(eng_ctrl), 0);
        chk({tag, "_eng_str"}, int'(eng_str), 0);
        chk({tag, "_eng_data"}, int'(eng_data), 0);
        chk({tag, "_tot0"}, int'(tot0), 0);
        chk({tag, "_tot1"}, int'(tot1), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        int gid, gnum, nacc, gap, sid, snum;
        bit seen;
        int sat_exp[5];

        tbl[0] = '{1'b1, 4'b1001, 8'b00100101, 1'b0, 4'b0000, 8'b00000000, 0, 1, 1, 0};
        tbl[1] = '{1'b1, 4'b0000, 8'b00000000, 1'b1, 4'b1000, 8'b10001000, 1, 2, 1, 2};
        tbl[2] = '{1'b0, 4'b0000, 8'b00000000, 1'b1, 4'b1111, 8'b11111111, 1, 5, 1, 7};
        tbl[3] = '{1'b1, 4'b0101, 8'b01010101, 1'b1, 4'b1111, 8'b11111111, 0, 3, 4, 7};
        tbl[4] = '{1'b0, 4'b0000, 8'b00000000, 1'b1, 4'b1100, 8'b00000000, 1, 0, 4, 7};
        tbl[5] = '{1'b1, 4'b0011, 8'b00111100, 1'b0, 4'b0000, 8'b00000000, 0, 1, 5, 7};
        sat_exp[0] = 5; sat_exp[1] = 10; sat_exp[2] = 15; sat_exp[3] = 15; sat_exp[4] = 0;

        RST = 1'b1; clr_tot = 1'b0; resp_ready = 1'b1; force_en = 1'b0; force_val = 8'd0;
        req0_valid = 1'b0; req0_str = 4'd0; req0_data = 8'd0;
        req1_valid = 1'b0; req1_str = 4'd0; req1_data = 8'd0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i], gid, gnum);
            chk("tbl_id", gid, tbl[i].e_id);
            chk("tbl_num", gnum, tbl[i].e_num);
            chk("tbl_tot0", int'(tot0), tbl[i].e_t0);
            chk("tbl_tot1", int'(tot1), tbl[i].e_t1);
        end

        // Both requesters permanently valid: grants alternate, one idle cycle between jobs
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        nacc = 0; gap = 0;
        for (int i = 0; i < 80 && nacc < 6; i++) begin
            step();
            if (ev_acc) begin
                chk("alt_grant", int'(ev_id), (nacc % 2 == 0) ? 1 : 0);
                if (nacc > 0) chk("idle_gap", gap, 1);
                nacc++; gap = 0;
                req0_str = 4'($urandom); req0_data = 8'($urandom);
                req1_str = 4'($urandom); req1_data = 8'($urandom);
            end else if (!busy) begin
                gap++;
            end
        end
        chk("alt_jobs", nacc, 6);
        drain();

        // Consumer stall: response held, nothing accepted, engine stays out of run
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            seen = resp_valid;
        end
        chk("stall_resp_seen", int'(seen), 1);
        sid = int'(resp_id); snum = int'(resp_num);
        chk("stall_grant", sid, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_id", int'(resp_id), sid);
            chk("stall_num", int'(resp_num), snum);
            chk("stall_no_run", (eng_ctrl == 2'b01) ? 1 : 0, 0);
        end
        resp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (ev_acc) begin
                seen = 1'b1;
                chk("post_stall_grant", int'(ev_id), 0);
            end
        end
        chk("accept_after_stall", int'(seen), 1);
        drain();

        // Saturation of tot0 and clear coinciding with the final capture
        clr_tot = 1'b1;
        step();
        clr_tot = 1'b0;
        chk("clr_tot0", int'(tot0), 0);
        force_en = 1'b1; force_val = 8'd5;
        v = '{1'b1, 4'b0110, 8'b10100011, 1'b0, 4'b0000, 8'b00000000, 0, 5, 0, 0};
        for (int k = 0; k < 5; k++) begin
            clr_on_cap = (k == 4);
            run_job(v, gid, gnum);
            chk("sat_num", gnum, 5);
            chk("sat_tot0", int'(tot0), sat_exp[k]);
        end
        clr_on_cap = 1'b0; force_en = 1'b0;

        // Reset asserted during RUN
        v = '{1'b1, 4'b1010, 8'b01010110, 1'b0, 4'b0000, 8'b00000000, 0, 0, 0, 0};
        req0_valid = v.v0; req0_str = v.s0; req0_data = v.d0; resp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (ev_acc) req0_valid = 1'b0;
            seen = (eng_ctrl == 2'b01);
        end
        chk("mid_rst_reached_run", int'(seen), 1);
        step();
        RST = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 8; i++) step();
        v = '{1'b1, 4'b1001, 8'b00100101, 1'b1, 4'b1000, 8'b10001000, 0, 1, 1, 0};
        run_job(v, gid, gnum);
        chk("post_rst_id", gid, 0);
        chk("post_rst_num", gnum, 1);
        chk("post_rst_tot0", int'(tot0), 1);
        v = '{1'b0, 4'b0000, 8'b00000000, 1'b1, 4'b1000, 8'b10001000, 1, 2, 1, 2};
        run_job(v, gid, gnum);
        chk("post_rst2_id", gid, 1);
        chk("post_rst2_num", gnum, 2);
        chk("post_rst2_tot1", int'(tot1), 2);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_str   = 4'($urandom_range(0, 3));
            req1_str   = 4'($urandom);
            req0_data  = 8'($urandom);
            req1_data  = 8'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            clr_tot    = ($urandom_range(0, 39) == 0);
            step();
        end
        clr_tot = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
